// File: rtl/mips32_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// mips32_hazard_scoreboard_if
//
// Bundle between the ID stage and the register hazard scoreboard.
//
//   ID stage -> scoreboard (master drives):
//     id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en,
//     id_halt, flush
//   scoreboard -> ID stage (slave drives):
//     stall, issue, busy_mask[NREGS], halted, drained, stall_cycles[CNT_W]
//
// NREGS/REG_AW/CNT_W must match the parameters of the scoreboard that is
// bound to the slave modport.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mips32_hazard_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  // Instruction currently held in ID
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic              id_rs_used;
  logic [REG_AW-1:0] id_rt;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_halt;
  logic              flush;

  // Scoreboard responses
  logic              stall;
  logic              issue;
  logic [NREGS-1:0]  busy_mask;
  logic              halted;
  logic              drained;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_rd, id_wr_en, id_halt, flush,
    input  stall, issue, busy_mask, halted, drained, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_rd, id_wr_en, id_halt, flush,
    output stall, issue, busy_mask, halted, drained, stall_cycles
  );

endinterface

// File: rtl/mips32_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// mips32_hazard_scoreboard
//
// Register scoreboard beside the ID stage of the pipelined MIPS32 core.
// Every issued register write arms a 4-bit countdown for its destination;
// an instruction whose used sources are still counting is held in ID.
// HLT is latched, and the block reports when the pipeline has drained
// after the halt plus a saturating count of stall cycles.
//
// Ports:
//   clk1  - single clock, rising edge
//   rst   - asynchronous, active-high reset
//   sb    - slave side of mips32_hazard_scoreboard_if:
//             in : id_valid, id_rs/_used, id_rt/_used, id_rd, id_wr_en,
//                  id_halt, flush
//             out: stall, issue (combinational on the ID inputs),
//                  busy_mask (combinational on the counters),
//                  halted, drained, stall_cycles (registered)
//
// Parameters:
//   NREGS     - architectural registers, R0 hardwired zero (<= 2**REG_AW)
//   REG_AW    - register index width
//   WB_LAT    - cycles from issue until the write completes (1..15)
//   WB_BYPASS - 1: write-first register file, a counter of 1 is readable
//   CNT_W     - width of the stall statistics counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mips32_hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REG_AW    = 5,
  parameter int WB_LAT    = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk1,
  input  logic                        rst,
  mips32_hazard_scoreboard_if.slave   sb
);

  typedef logic [3:0] cnt_t;

  localparam cnt_t LAT = cnt_t'(WB_LAT);

  // Per-register countdown: nonzero means a write to that register is
  // still in flight. Entry 0 exists only to keep indexing uniform and is
  // held at zero.
  cnt_t             cnt_q [NREGS];
  cnt_t             cnt_d [NREGS];
  logic             halted_q,    halted_d;
  logic             drained_q,   drained_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  cnt_t             rs_cnt, rt_cnt;
  logic             rs_haz, rt_haz, hazard;
  logic             stall, issue, wr_load, all_zero;
  logic [NREGS-1:0] busy;

  // A source is unsafe to read while its counter says the write has not
  // landed yet. With a write-first register file the final cycle (count 1)
  // already returns the new value.
  function automatic logic pending(input cnt_t c);
    if (WB_BYPASS != 0) pending = (c > 4'd1);
    else                pending = (c != 4'd0);
  endfunction

  // ---- source lookup and hazard detection --------------------------------
  // NOTE: every variable assigned in an always_comb gets a default first so
  // that no path leaves it holding its old value, which would infer a latch.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    // Loop starts at 1, so R0 (and any index beyond NREGS) reads as idle.
    for (int i = 1; i < NREGS; i++) begin
      if (sb.id_rs == REG_AW'(i)) rs_cnt = cnt_q[i];
      if (sb.id_rt == REG_AW'(i)) rt_cnt = cnt_q[i];
    end

    rs_haz = sb.id_rs_used & pending(rs_cnt);
    rt_haz = sb.id_rt_used & pending(rt_cnt);
    // HLT carries no operands, so its source fields are ignored.
    hazard = ~sb.id_halt & (rs_haz | rt_haz);

    stall  = sb.id_valid &  hazard & ~sb.flush & ~halted_q;
    issue  = sb.id_valid & ~hazard & ~sb.flush & ~halted_q;

    // Writes to R0 are dropped; HLT never arms a counter.
    wr_load = issue & ~sb.id_halt & sb.id_wr_en & (sb.id_rd != '0);
  end

  // ---- next-state ---------------------------------------------------------
  always_comb begin
    all_zero = 1'b1;
    busy     = '0;
    cnt_d[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      busy[i]  = (cnt_q[i] != 4'd0);
      all_zero = all_zero & ~busy[i];
      // The hazard check above used the old value, so an instruction whose
      // rd matches its own rs/rt never stalls on its own reload.
      cnt_d[i] = busy[i] ? (cnt_q[i] - 4'd1) : 4'd0;
      if (wr_load && (sb.id_rd == REG_AW'(i))) cnt_d[i] = LAT;
    end

    halted_d  = halted_q | (issue & sb.id_halt);
    // Built from the current counters, so drained rises one cycle after
    // the last counter is seen at zero.
    drained_d = halted_q & all_zero;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // ---- state --------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is reset like any control flop; busy_mask and
      // the hazard logic read it directly, so it can never start as garbage.
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      halted_q    <= 1'b0;
      drained_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      halted_q    <= halted_d;
      drained_q   <= drained_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---- outputs ------------------------------------------------------------
  assign sb.stall        = stall;
  assign sb.issue        = issue;
  assign sb.busy_mask    = busy;
  assign sb.halted       = halted_q;
  assign sb.drained      = drained_q;
  assign sb.stall_cycles = stall_cnt_q;

endmodule
